sfifo_uart_tx: RTL and testbench
================================

Name: sfifo_uart_tx

Overview:
Downstream consumer of the synchronous byte FIFO. Pops one byte at a time through the FIFO's rd_en/empty interface, honouring the FIFO's one-cycle registered read latency, and serialises each byte as an asynchronous UART frame. Frame format is start bit, 8 data bits LSB-first, optional parity bit, one stop bit. Sits between the FIFO read port and the chip-level TX pin.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2.
PARITY_EN, 0, 1 inserts a parity bit after D7; 0 omits it.
PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.

Ports:
clk  input  1  single system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-low reset: rst=0 resets immediately, independent of clk.
tx_en  input  1  1 permits starting a new frame; a frame already in progress always completes.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  8  FIFO registered read data; valid in the cycle after a pop edge.
fifo_rd_en  output  1  pop request to the FIFO; combinational from state, high for exactly one cycle per frame.
tx  output  1  serial line, registered, idle high.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0): state=IDLE, tx=1, busy=0, fifo_rd_en=0, bit timer=0, bit index=0, shift register=0. Reset mid-frame aborts the frame: tx returns high asynchronously. A byte already popped is discarded; it is not re-read.
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE: fifo_rd_en = tx_en & !fifo_empty. If it is 1 at edge N, the next state is FETCH. Otherwise stay in IDLE.
- FETCH (cycle after edge N): fifo_data is valid. At edge N+1:
  - shift register <= fifo_data
  - parity <= ^fifo_data ^ PARITY_ODD
  - tx <= 0
  - bit timer <= 0
  - state <= START
- Bit timer: counts 0..CLKS_PER_BIT-1 and generates a tick on its terminal count. Each of START, DATA (per bit), PARITY and STOP lasts exactly CLKS_PER_BIT cycles.
- START: on tick, tx <= shift[0], bit index <= 0, state <= DATA.
- DATA: on tick, shift right and increment bit index.
  - After bit index 7: go to PARITY with tx <= parity if PARITY_EN=1; otherwise go to STOP with tx <= 1.
  - Otherwise tx <= next data bit.
- PARITY: on tick, tx <= 1, state <= STOP.
- STOP: on tick, state <= IDLE, tx stays 1.
- Frame timing (tx low edge to STOP exit): 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- Back-to-back frames: minimum line idle is CLKS_PER_BIT+2 cycles (STOP, IDLE, FETCH). There are no other inter-frame gaps.
- fifo_rd_en is never asserted when fifo_empty=1, outside IDLE, or when tx_en=0. This gives exactly one pop per frame, so the FIFO is never underflowed.
- tx_en deasserted mid-frame has no effect until the frame returns to IDLE.
- Bit index width: 3 bits. Bit timer width: $clog2(CLKS_PER_BIT). Timer wraps to 0 on every tick; no overflow is possible.

Decomposition:
- Shared package/include holds:
  - state encoding constants (IDLE=0, FETCH=1, START=2, DATA=3, PARITY=4, STOP=5; 3-bit)
  - DATA_W=8
  - frame-length helper constant (FRAME_BITS = 10 + PARITY_EN)
- One natural sub-module: sfifo_bit_timer.
  - Parameterised by CLKS_PER_BIT.
  - Inputs clk, rst, clear; output tick.
  - The FSM pulses clear on entry to START.
- The FSM, shift register and parity logic stay in sfifo_uart_tx.

Test Plan:
- Idle/reset: rst=0 with fifo_empty=1 -> tx=1, busy=0, fifo_rd_en=0. After release with FIFO still empty, all three hold for 100 cycles.
- Single byte, CLKS_PER_BIT=4, PARITY_EN=0, FIFO holding 0xA5:
  - fifo_rd_en high for exactly 1 cycle
  - tx low 2 cycles later
  - tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1
  - busy falls 40 cycles after tx falls
- Parity, CLKS_PER_BIT=4, PARITY_EN=1:
  - 0x03 with PARITY_ODD=0 -> parity bit 0
  - 0x07 with PARITY_ODD=0 -> parity bit 1
  - 0x07 with PARITY_ODD=1 -> parity bit 0
  - each frame is 44 cycles long
- Back-to-back: FIFO preloaded with 0x11,0x22,0x33, tx_en=1 -> three frames in order, each stop-to-start idle exactly 6 cycles (CLKS_PER_BIT=4), FIFO empty afterwards, no fourth fifo_rd_en pulse.
- Flow control: tx_en=0 with FIFO non-empty -> no pop, tx=1. Raise tx_en -> pop on the next edge. Drop tx_en mid-frame -> frame completes, no further pop.
- Reset mid-frame: assert rst=0 during DATA bit 3 of 0xFF -> tx=1 immediately, state IDLE. After release, next frame carries the next FIFO byte.

Source files
------------

// File: rtl/sfifo_uart_tx_pkg.sv
// Shared constants for the FIFO-fed UART transmitter: FSM encoding, byte width
// and frame-length helper.
package sfifo_uart_tx_pkg;

  localparam int DATA_W          = 8;
  localparam int FRAME_BITS_BASE = 10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  // Serial bits per frame: start + 8 data + optional parity + stop.
  function automatic int frame_bits(input int parity_en);
    return FRAME_BITS_BASE + ((parity_en != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/sfifo_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and ticks on the terminal count.
// clear restarts the period at zero.
module sfifo_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int             CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sfifo_uart_tx.sv
// UART transmitter draining a synchronous byte FIFO: one pop per frame,
// start + 8 data bits LSB-first + optional parity + one stop bit.
module sfifo_uart_tx
  import sfifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);
  localparam logic       ODD      = (PARITY_ODD != 0);

  logic [2:0]        state;
  logic [DATA_W-1:0] shift;
  logic [2:0]        bit_idx;
  logic              parity;
  logic              armed;
  logic              tick;
  logic              timer_clear;

  // FIFO read handshake: a pop happens on the rising edge where fifo_rd_en=1;
  // fifo_rd_en is only raised in IDLE with fifo_empty=0 and tx_en=1, and the
  // popped byte is taken from fifo_data one cycle later (FETCH).
  // armed keeps the pop request low while reset is applied.
  assign fifo_rd_en  = armed && (state == ST_IDLE) && tx_en && !fifo_empty;
  assign busy        = (state != ST_IDLE);
  assign timer_clear = (state == ST_FETCH);

  sfifo_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      shift   <= '0;
      bit_idx <= '0;
      parity  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_rd_en) state <= ST_FETCH;
        end
        ST_FETCH: begin
          shift  <= fifo_data;
          parity <= (^fifo_data) ^ ODD;
          tx     <= 1'b0;
          state  <= ST_START;
        end
        ST_START: begin
          if (tick) begin
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift   <= {1'b0, shift[DATA_W-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                tx    <= parity;
                state <= ST_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              tx <= shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfifo_uart_tx.sv
// Bench for sfifo_uart_tx: three lanes (no parity, even, odd), each with a FIFO
// model, a frame decoder against an expected-byte queue, and directed+random stimulus.
module tb_sfifo_uart_tx;

  localparam int CPB    = 4;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  function automatic void check(input string name, input int lane_id, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s lane%0d: got %0d expected %0d", name, lane_id, act, req);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int PE   = (g > 0) ? 1 : 0;
    localparam int PO   = (g == 2) ? 1 : 0;
    localparam int FLEN = (10 + PE) * CPB;

    logic       rst        = 1'b0;
    logic       tx_en      = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;

    logic [7:0] fifo_q[$];
    logic [7:0] pend_q[$];
    logic [7:0] exp_q[$];

    int   cyc          = 0;
    int   last_pop     = -100;
    int   pops         = 0;
    int   frames       = 0;
    int   aborts       = 0;
    int   expect_start = -1;
    logic pop_latched  = 1'b0;
    bit   done         = 1'b0;

    sfifo_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .PARITY_EN    (PE),
      .PARITY_ODD   (PO)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_en      (tx_en),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .tx         (tx),
      .busy       (busy)
    );

    // FIFO model: registered read data, pushes become visible one edge later.
    initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pop_latched) begin
        if (fifo_q.size() == 0) check("underflow", g, 1, 0);
        else fifo_data = fifo_q.pop_front();
      end
      while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
      fifo_empty = (fifo_q.size() == 0);
    end

    // Per-cycle protocol checks.
    initial forever begin
      @(negedge clk);
      pop_latched = fifo_rd_en;
      if (fifo_rd_en) begin
        pops++;
        last_pop = cyc;
        check("rd_en_legal", g, int'({rst, busy, fifo_empty, tx_en}), 9);
      end
      if (!busy) check("idle_tx_high", g, int'(tx), 1);
      if (!rst) check("rst_rd_en", g, int'(fifo_rd_en), 0);
    end

    // Frame decoder / scoreboard.
    initial begin
      int         sc;
      int         stable_bad;
      int         busy_bad;
      bit         aborted;
      logic [10:0] bits;
      logic [10:0] ef;
      logic [7:0]  e;
      logic        par;
      forever begin
        @(negedge clk);
        if (rst && !tx) begin
          sc = cyc; stable_bad = 0; busy_bad = 0; aborted = 0; bits = '1;
          check("pop_to_start", g, sc - last_pop, 2);
          if (expect_start >= 0) check("b2b_gap", g, sc, expect_start);
          for (int k = 0; k < FLEN; k++) begin
            if (k > 0) @(negedge clk);
            if (!rst) begin
              aborted = 1;
              break;
            end
            if (!busy) busy_bad++;
            if (k % CPB == 0) bits[k / CPB] = tx;
            else if (tx != bits[k / CPB]) stable_bad++;
          end
          if (aborted) begin
            aborts++;
            expect_start = -1;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end else begin
            @(negedge clk);
            check("busy_fall", g, int'(busy), 0);
            check("busy_held", g, busy_bad, 0);
            check("bit_stable", g, stable_bad, 0);
            frames++;
            if (exp_q.size() == 0) begin
              check("unexpected_frame", g, 1, 0);
            end else begin
              e   = exp_q.pop_front();
              par = 1'(($countones(e) + PO) % 2);
              ef  = (PE != 0) ? {1'b1, par, e, 1'b0} : {2'b11, e, 1'b0};
              check("data_byte", g, int'(bits[8:1]), int'(e));
              check("frame_bits", g, int'(bits), int'(ef));
            end
            expect_start = (tx_en && !fifo_empty && rst) ? cyc + 2 : -1;
          end
        end
      end
    end

    task automatic push(input logic [7:0] b);
      pend_q.push_back(b);
      exp_q.push_back(b);
    endtask

    task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
    endtask

    task automatic wait_drain(input string tag);
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while ((exp_q.size() != 0 || pend_q.size() != 0 || busy || !rst) && n < BUDGET);
      check(tag, g, (n < BUDGET) ? 1 : 0, 1);
    endtask

    task automatic wait_tx(input logic level, input string tag);
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (tx != level && n < BUDGET);
      check(tag, g, (n < BUDGET) ? 1 : 0, 1);
    endtask

    task automatic wait_busy(input logic level, input string tag);
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (busy != level && n < BUDGET);
      check(tag, g, (n < BUDGET) ? 1 : 0, 1);
    endtask

    // Stimulus.
    initial begin
      int p0;
      int a0;
      int idle_bad;
      step(3);
      check("reset_tx", g, int'(tx), 1);
      check("reset_busy", g, int'(busy), 0);
      check("reset_rd_en", g, int'(fifo_rd_en), 0);
      rst   = 1'b1;
      tx_en = 1'b1;
      idle_bad = 0;
      repeat (100) begin
        @(negedge clk);
        if (tx != 1'b1 || busy != 1'b0 || fifo_rd_en != 1'b0) idle_bad++;
      end
      check("idle_hold", g, idle_bad, 0);

      step(1);
      p0 = pops;
      push(8'hA5);
      wait_drain("drain_a5");
      check("a5_pops", g, pops - p0, 1);

      step(1);
      push(8'h03);
      wait_drain("drain_03");
      step(1);
      push(8'h07);
      wait_drain("drain_07");

      step(1);
      tx_en = 1'b0;
      push(8'h11); push(8'h22); push(8'h33);
      p0 = pops;
      step(20);
      check("no_pop_disabled", g, pops - p0, 0);
      check("tx_idle_disabled", g, int'(tx), 1);
      tx_en = 1'b1;
      @(negedge clk);
      check("pop_on_enable", g, int'(fifo_rd_en), 1);
      wait_drain("drain_b2b");
      check("b2b_pops", g, pops - p0, 3);
      check("fifo_empty_after", g, int'(fifo_empty), 1);
      step(50);
      check("no_fourth_pop", g, pops - p0, 3);

      p0 = pops;
      push(8'h5A); push(8'hC3);
      wait_busy(1'b1, "wait_busy_5a");
      step(10);
      tx_en = 1'b0;
      wait_busy(1'b0, "wait_idle_5a");
      step(60);
      check("single_pop_after_drop", g, pops - p0, 1);
      check("byte_left", g, fifo_q.size(), 1);
      tx_en = 1'b1;
      wait_drain("drain_c3");

      step(1);
      p0 = pops;
      a0 = aborts;
      push(8'hFF); push(8'h3C);
      wait_tx(1'b0, "wait_ff_start");
      repeat (17) @(negedge clk);
      step(1);
      rst = 1'b0;
      #1;
      check("rst_tx_high", g, int'(tx), 1);
      check("rst_busy", g, int'(busy), 0);
      check("rst_rd_en_now", g, int'(fifo_rd_en), 0);
      step(3);
      rst = 1'b1;
      wait_drain("drain_after_rst");
      check("rst_abort_seen", g, aborts - a0, 1);
      check("rst_pops", g, pops - p0, 2);

      for (int i = 0; i < 10; i++) begin
        push(8'($urandom_range(0, 255)));
        step($urandom_range(1, FLEN + 10));
      end
      wait_drain("drain_random");

      check("pops_vs_frames", g, pops, frames + aborts);
      done = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(lane[0].done && lane[1].done && lane[2].done) && t < 40000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 40000) check("global_timeout", -1, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
